reg_bank8_nbit: RTL and testbench

- Eight-entry, N-bit register bank in the datapath. It sits directly upstream of the 8:1 N-bit select mux.
- Outputs Q00..Q07 drive the mux data inputs I00..I07 one-for-one.
- Also provides one bypassed read port, one write port, and a sequenced 8-cycle bulk-clear operation with a busy indication.

---
 rtl/reg_bank8_nbit.sv | 132 +++++++++++++
 tb/tb_reg_bank8_nbit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank8_nbit.sv
// Eight-entry N-bit register bank feeding the 8:1 select mux.
// One write port, one combinational read port with write bypass, and an
// 8-cycle sequenced bulk clear with a BUSY indication. WERR pulses for one
// cycle after every rejected write.
module reg_bank8_nbit #(
  parameter int N       = 8,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         WE,
  input  logic [2:0]   WA,
  input  logic [N-1:0] WD,
  input  logic [2:0]   RA,
  output logic [N-1:0] RD,
  input  logic         CLR,
  output logic         BUSY,
  output logic         WERR,
  output logic [N-1:0] Q00,
  output logic [N-1:0] Q01,
  output logic [N-1:0] Q02,
  output logic [N-1:0] Q03,
  output logic [N-1:0] Q04,
  output logic [N-1:0] Q05,
  output logic [N-1:0] Q06,
  output logic [N-1:0] Q07
);

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [2:0]   cnt, cnt_next;
  logic [N-1:0] regs [8];
  logic [N-1:0] view [8];
  logic         wr_accept;
  logic         wr_reject;
  logic         r0_discard;
  logic         werr_q;

  // Next-state, clear counter and write accept/reject decode.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_accept  = 1'b0;
    wr_reject  = 1'b0;
    r0_discard = ZERO_R0 && (WA == 3'd0);
    case (state)
      IDLE: begin
        if (CLR) begin
          // A clear request wins over a simultaneous write.
          state_next = CLEARING;
          cnt_next   = 3'd0;
          wr_reject  = WE;
        end else begin
          // Writes to a hardwired R0 vanish silently; they are not errors.
          wr_accept  = WE && !r0_discard;
        end
      end
      CLEARING: begin
        wr_reject = WE;
        if (cnt == 3'd7) begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next   = cnt + 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // State, counter and error-pulse registers; reset has priority.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      werr_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      werr_q <= wr_reject;
    end
  end

  // Register array: reset, one entry cleared per CLEARING cycle, or a write.
  // NOTE: the array is reset because a zeroed bank after reset is visible
  // on Q00..Q07; this is a flop array, not an inferred RAM.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (state == CLEARING) begin
      regs[cnt] <= '0;
    end else if (wr_accept) begin
      regs[WA] <= WD;
    end
  end

  // Architectural view of the bank: R0 reads as constant zero when hardwired.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      view[i] = (ZERO_R0 && (i == 0)) ? '0 : regs[i];
    end
  end

  // Read port: forward write data only for a write that will actually land.
  always_comb begin
    RD = view[RA];
    if (wr_accept && (WA == RA)) RD = WD;
  end

  assign BUSY = (state == CLEARING);
  assign WERR = werr_q;
  assign Q00  = view[0];
  assign Q01  = view[1];
  assign Q02  = view[2];
  assign Q03  = view[3];
  assign Q04  = view[4];
  assign Q05  = view[5];
  assign Q06  = view[6];
  assign Q07  = view[7];

endmodule

// File: tb/tb_reg_bank8_nbit.sv
// Bench for reg_bank8_nbit: two instances (R0 hardwired and R0 ordinary)
// share one stimulus stream and are compared every cycle against a
// behavioural model of the bank, plus directed literal checks.
module tb_reg_bank8_nbit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic [2:0] wa  = 3'd0;
  logic [7:0] wd  = 8'h00;
  logic [2:0] ra  = 3'd0;
  logic       clr = 1'b0;

  logic [7:0] rd1, rd0;
  logic       busy1, busy0, werr1, werr0;
  wire  [7:0] q1 [8];
  wire  [7:0] q0 [8];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bank8_nbit #(.N(8), .ZERO_R0(1'b1)) dut1 (
    .Clk(clk), .Rst(rst), .WE(we), .WA(wa), .WD(wd), .RA(ra), .RD(rd1),
    .CLR(clr), .BUSY(busy1), .WERR(werr1),
    .Q00(q1[0]), .Q01(q1[1]), .Q02(q1[2]), .Q03(q1[3]),
    .Q04(q1[4]), .Q05(q1[5]), .Q06(q1[6]), .Q07(q1[7])
  );

  reg_bank8_nbit #(.N(8), .ZERO_R0(1'b0)) dut0 (
    .Clk(clk), .Rst(rst), .WE(we), .WA(wa), .WD(wd), .RA(ra), .RD(rd0),
    .CLR(clr), .BUSY(busy0), .WERR(werr0),
    .Q00(q0[0]), .Q01(q0[1]), .Q02(q0[2]), .Q03(q0[3]),
    .Q04(q0[4]), .Q05(q0[5]), .Q06(q0[6]), .Q07(q0[7])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: bank contents, clear progress, error pulse.
  logic [7:0] m1 [8];
  logic [7:0] m0 [8];
  bit         m_busy  = 1'b0;
  int         m_left  = 0;   // entries still to be zeroed by the clear
  bit         m_werr  = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m1[i]) begin m1[i] = 8'h00; m0[i] = 8'h00; end
      m_busy = 1'b0; m_left = 0; m_werr = 1'b0;
    end else if (m_busy) begin
      m1[8 - m_left] = 8'h00;
      m0[8 - m_left] = 8'h00;
      m_left--;
      m_busy = (m_left != 0);
      m_werr = we;
    end else begin
      m_werr = we && clr;
      if (clr) begin
        m_busy = 1'b1; m_left = 8;
      end else if (we) begin
        m0[wa] = wd;
        if (wa != 3'd0) m1[wa] = wd;
      end
    end
    m_valid = 1'b1;
  end

  // Every-cycle comparison, mid-cycle with the current inputs applied.
  always @(negedge clk) begin
    if (m_valid) begin
      logic       acc;
      logic [7:0] e1, e0;
      acc = !m_busy && !clr && we;
      e1  = (acc && wa != 3'd0 && wa == ra) ? wd : m1[ra];
      e0  = (acc && wa == ra) ? wd : m0[ra];
      check("rd_r0hw", rd1, e1);
      check("rd_r0reg", rd0, e0);
      check("busy_r0hw", busy1, m_busy);
      check("busy_r0reg", busy0, m_busy);
      check("werr_r0hw", werr1, m_werr);
      check("werr_r0reg", werr0, m_werr);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("q_r0hw[%0d]", i), q1[i], m1[i]);
        check($sformatf("q_r0reg[%0d]", i), q0[i], m0[i]);
      end
    end
  end

  // Apply one cycle of inputs just after an edge, then stop mid-cycle.
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [2:0] a, input logic [7:0] d, input logic [2:0] rdaddr);
    @(posedge clk); #1;
    rst = r; clr = c; we = w; wa = a; wd = d; ra = rdaddr;
    @(negedge clk);
  endtask

  task automatic idle(input logic [2:0] rdaddr);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, rdaddr);
  endtask

  initial begin
    // Reset.
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0);
    idle(3'd0);
    check("lit_reset_busy", busy1, 1'b0);
    check("lit_reset_werr", werr1, 1'b0);
    check("lit_reset_q07", q0[7], 8'h00);

    // Writes 1..7 with read-address tracking the write (bypass visible).
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 3'(i), 8'h10 + 8'(i), 3'(i));
      check("lit_write_bypass", rd1, 8'h10 + 8'(i));
    end
    idle(3'd0);
    for (int i = 1; i < 8; i++) check("lit_write_q", q1[i], 8'h10 + 8'(i));
    check("lit_write_q00", q1[0], 8'h00);

    // R0 hardwire versus ordinary R0.
    step(1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, 3'd0);
    check("lit_r0hw_rd", rd1, 8'h00);
    check("lit_r0reg_rd", rd0, 8'hFF);
    idle(3'd0);
    check("lit_r0hw_q", q1[0], 8'h00);
    check("lit_r0reg_q", q0[0], 8'hFF);
    check("lit_r0hw_werr", werr1, 1'b0);

    // Bypass.
    step(1'b0, 1'b0, 1'b1, 3'd3, 8'h22, 3'd0);
    step(1'b0, 1'b0, 1'b1, 3'd3, 8'h5A, 3'd3);
    check("lit_bypass_rd", rd1, 8'h5A);
    check("lit_bypass_qold", q1[3], 8'h22);
    step(1'b0, 1'b0, 1'b1, 3'd3, 8'h77, 3'd4);
    check("lit_bypass_qnew", q1[3], 8'h5A);
    check("lit_bypass_other", rd1, 8'h14);
    idle(3'd3);

    // Bulk clear with an ignored second request at k+3.
    step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0);
    for (int m = 1; m <= 9; m++) begin
      step(1'b0, (m == 3), 1'b0, 3'd0, 8'h00, 3'd0);
      check("lit_clear_busy", busy1, (m <= 8));
    end
    check("lit_clear_q07", q1[7], 8'h00);

    // Collision: clear with a write, then writes during clearing.
    step(1'b0, 1'b0, 1'b1, 3'd2, 8'h44, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd2, 8'h33, 3'd2);
    idle(3'd0);
    check("lit_coll_werr", werr1, 1'b1);
    check("lit_coll_q02", q1[2], 8'h44);
    step(1'b0, 1'b0, 1'b1, 3'd6, 8'hAA, 3'd6);
    check("lit_coll_werr_once", werr1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'd6, 8'hAB, 3'd6);
    check("lit_coll_werr_b2b1", werr1, 1'b1);
    idle(3'd0);
    check("lit_coll_werr_b2b2", werr1, 1'b1);
    idle(3'd0);
    check("lit_coll_werr_end", werr1, 1'b0);
    begin
      int n = 0;
      while (busy1 && n < 12) begin idle(3'd0); n++; end
      check("clear_done_bound", busy1, 1'b0);
    end
    check("lit_coll_q06", q1[6], 8'h00);

    // Reset mid-clear, then a normal write.
    step(1'b0, 1'b0, 1'b1, 3'd5, 8'h55, 3'd0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0);
    idle(3'd0);
    idle(3'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0);
    step(1'b0, 1'b0, 1'b1, 3'd6, 8'h66, 3'd0);
    check("lit_rstmid_busy", busy1, 1'b0);
    check("lit_rstmid_q05", q1[5], 8'h00);
    idle(3'd6);
    check("lit_rstmid_write", q1[6], 8'h66);

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
           8'($urandom), 3'($urandom_range(0, 7)));
    end
    idle(3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
